ysyx_25020037_wbu: RTL
======================

Name: ysyx_25020037_wbu

Overview:
- Write-back/commit stage directly downstream of the load-store unit.
- Takes one retiring instruction per handshake and drives the GPR write port.
- Owns the machine CSRs (mstatus, mtvec, mepc, mcause) and resolves traps (ecall, access fault, mret).
- Hands the committed next-PC to the fetch unit over a valid/ready handshake, so only one instruction is in flight.

Parameters:
- GPR_AW, 4, GPR index width (RV32E).
- MSTATUS_RST, 32'h0000_1800, mstatus reset value (MPP=M).
- MTVEC_RST, 32'h0000_0000, mtvec reset value.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- lsu_valid  in  1  LSU holds a retiring instruction.
- wbu_ready  out  1  WBU can accept this cycle.
- lu_pc  in  32  PC of the instruction.
- lu_dnpc  in  32  sequential/branch next PC computed by EXU.
- lu_rd  in  GPR_AW  destination register.
- lu_gpr_we  in  1  GPR write request.
- lu_wdata  in  32  GPR write data (ALU result or processed load data).
- lu_is_read  in  1  instruction was a load.
- lu_is_write  in  1  instruction was a store.
- lu_access_fault  in  1  bus returned a non-OKAY response.
- lu_ecall  in  1  ecall.
- lu_mret  in  1  mret.
- lu_csr_we  in  1  CSR write request.
- lu_csr_waddr  in  12  CSR write address.
- lu_csr_wdata  in  32  CSR write data.
- csr_raddr  in  12  EXU CSR read address.
- csr_rdata  out  32  combinational CSR read data.
- gpr_we  out  1  GPR write strobe.
- gpr_waddr  out  GPR_AW  GPR write index.
- gpr_wdata  out  32  GPR write data.
- wbu_valid  out  1  commit/next-PC valid to IFU.
- ifu_ready  in  1  IFU accepts next PC.
- wbu_npc  out  32  committed next PC.
- wbu_trap  out  1  the commit was a trap redirect.

Behaviour:
- Reset: when rst==0 at posedge clk, all outputs and registers are cleared: state=IDLE, wbu_valid=0, gpr_we=0, gpr_waddr=0, gpr_wdata=0, wbu_npc=0, wbu_trap=0, mstatus=MSTATUS_RST, mtvec=MTVEC_RST, mepc=0, mcause=0. An instruction in flight when reset asserts is dropped with no GPR or CSR effect.
- wbu_ready = (state==IDLE). Accept happens when lsu_valid & wbu_ready. All lu_* fields are captured on accept; the LSU may change them afterwards.
- States:
  - IDLE → COMMIT on accept.
  - COMMIT lasts exactly one cycle → HANDOFF.
  - HANDOFF → IDLE when ifu_ready is sampled high while wbu_valid=1; otherwise it holds.
- COMMIT cycle, priority fault > ecall > mret > normal:
  - fault: mepc<=pc; mcause<=5 if is_read, 7 if is_write; npc=mtvec; trap=1; GPR and CSR writes suppressed.
  - ecall: mepc<=pc; mcause<=11; npc=mtvec; trap=1; GPR write suppressed.
  - mret: npc=mepc; mstatus.MIE(bit3)<=MPIE(bit7); MPIE<=1; trap=0.
  - normal: npc=dnpc; trap=0.
  - gpr_we pulses for this one cycle only when gpr_we_q & no fault/ecall & rd!=0, with gpr_waddr=rd and gpr_wdata=wdata.
  - CSR write is applied when csr_we_q & no fault/ecall, to addresses 0x300 mstatus, 0x305 mtvec, 0x341 mepc, 0x342 mcause. Writes to any other address are ignored.
  - If mret and a CSR write target mstatus in the same instruction, the mret update wins.
- HANDOFF: wbu_valid=1. wbu_npc and wbu_trap stay stable until the handshake completes. wbu_valid drops in the cycle after the handshake.
- Latency: accept at cycle N gives gpr_we at N+1 and wbu_valid at N+2. Minimum spacing between accepts is 3 cycles.
- csr_rdata: combinational from the current registers. Unknown addresses read 0. There is no bypass of a same-cycle write.
- Simultaneous fault and ecall: the fault wins, so mcause is 5 or 7.

Decomposition:
- Shared package/header:
  - CSR address constants (MSTATUS 0x300, MTVEC 0x305, MEPC 0x341, MCAUSE 0x342).
  - mcause codes (LOAD_FAULT 5, STORE_FAULT 7, ECALL_M 11).
  - mstatus bit positions (MIE 3, MPIE 7).
  - WBU state encoding (IDLE, COMMIT, HANDOFF).
- One sub-module: ysyx_25020037_csr_file, holding the four CSRs, the read mux, the write decode and the trap/mret update port. The WBU keeps the handshake FSM and commit logic.

Test Plan:
- Normal ALU op: pc=0x8000_0000, dnpc=0x8000_0004, rd=5, wdata=0x1234, ifu_ready=1 → gpr_we one cycle with waddr 5 and wdata 0x1234; wbu_npc=0x8000_0004, trap=0; wbu_ready high again 3 cycles after accept.
- rd=0 with gpr_we=1 → gpr_we never asserts; commit proceeds normally.
- Load fault: is_read=1, access_fault=1, mtvec preset 0x8000_0100 → mepc=pc, mcause=5, wbu_npc=0x8000_0100, trap=1, no GPR write. Same with is_write=1 → mcause=7.
- ecall then mret: ecall at pc 0x8000_0020 sets mepc=0x8000_0020 and mcause=11. Then mret with mstatus=0x80 → wbu_npc=0x8000_0020 and mstatus=0x88.
- Back-pressure: hold ifu_ready=0 for 4 cycles → wbu_valid and wbu_npc stay stable, wbu_ready stays 0, lsu_valid is not accepted; releasing ifu_ready completes the handoff in one cycle.
- Reset mid-flight: drive rst=0 during COMMIT → the next edge clears all outputs and mstatus reads 0x1800, with no CSR or GPR side effect.

Source files
------------

// File: rtl/ysyx_25020037_wbu_pkg.sv
// Shared definitions for the write-back unit: CSR addresses, mcause codes,
// mstatus bit positions and the WBU handshake state encoding.
package ysyx_25020037_wbu_pkg;

  localparam logic [11:0] CsrMstatus = 12'h300;
  localparam logic [11:0] CsrMtvec   = 12'h305;
  localparam logic [11:0] CsrMepc    = 12'h341;
  localparam logic [11:0] CsrMcause  = 12'h342;

  localparam logic [31:0] CauseLoadFault  = 32'd5;
  localparam logic [31:0] CauseStoreFault = 32'd7;
  localparam logic [31:0] CauseEcallM     = 32'd11;

  localparam int unsigned MstatusMieBit  = 3;
  localparam int unsigned MstatusMpieBit = 7;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCommit  = 2'd1,
    StHandoff = 2'd2
  } wbu_state_e;

  // mret: MIE <= MPIE, MPIE <= 1, all other bits untouched.
  function automatic logic [31:0] mret_mstatus(input logic [31:0] ms);
    logic [31:0] r;
    r                 = ms;
    r[MstatusMieBit]  = ms[MstatusMpieBit];
    r[MstatusMpieBit] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/ysyx_25020037_wbu_if.sv
// LSU->WBU retire handshake and WBU->IFU next-PC handshake.
//   master : upstream/downstream neighbours (LSU drives lu_*, IFU drives ifu_ready)
//   slave  : the WBU itself
interface ysyx_25020037_wbu_if #(
  parameter int unsigned GPR_AW = 4
);
  logic              lsu_valid;
  logic              wbu_ready;
  logic [31:0]       lu_pc;
  logic [31:0]       lu_dnpc;
  logic [GPR_AW-1:0] lu_rd;
  logic              lu_gpr_we;
  logic [31:0]       lu_wdata;
  logic              lu_is_read;
  logic              lu_is_write;
  logic              lu_access_fault;
  logic              lu_ecall;
  logic              lu_mret;
  logic              lu_csr_we;
  logic [11:0]       lu_csr_waddr;
  logic [31:0]       lu_csr_wdata;
  logic              wbu_valid;
  logic              ifu_ready;
  logic [31:0]       wbu_npc;
  logic              wbu_trap;

  modport master (
    output lsu_valid, lu_pc, lu_dnpc, lu_rd, lu_gpr_we, lu_wdata, lu_is_read, lu_is_write,
           lu_access_fault, lu_ecall, lu_mret, lu_csr_we, lu_csr_waddr, lu_csr_wdata,
           ifu_ready,
    input  wbu_ready, wbu_valid, wbu_npc, wbu_trap
  );

  modport slave (
    input  lsu_valid, lu_pc, lu_dnpc, lu_rd, lu_gpr_we, lu_wdata, lu_is_read, lu_is_write,
           lu_access_fault, lu_ecall, lu_mret, lu_csr_we, lu_csr_waddr, lu_csr_wdata,
           ifu_ready,
    output wbu_ready, wbu_valid, wbu_npc, wbu_trap
  );

endinterface

// File: rtl/ysyx_25020037_csr_file.sv
// Machine CSRs (mstatus, mtvec, mepc, mcause).
//   raddr/rdata          : combinational read, unknown addresses read 0
//   we/waddr/wdata       : software CSR write, unknown addresses ignored
//   trap/trap_pc/trap_cause : trap entry updates mepc/mcause
//   mret                 : mstatus MIE/MPIE restore, overrides a same-cycle mstatus write
//   mtvec/mepc           : current values for next-PC selection
module ysyx_25020037_csr_file
  import ysyx_25020037_wbu_pkg::*;
#(
  parameter logic [31:0] MSTATUS_RST = 32'h0000_1800,
  parameter logic [31:0] MTVEC_RST   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] raddr,
  output logic [31:0] rdata,
  input  logic        we,
  input  logic [11:0] waddr,
  input  logic [31:0] wdata,
  input  logic        trap,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_cause,
  input  logic        mret,
  output logic [31:0] mtvec,
  output logic [31:0] mepc
);

  logic [31:0] mstatus_q, mstatus_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;

  always_comb begin
    mstatus_d = mstatus_q;
    mtvec_d   = mtvec_q;
    mepc_d    = mepc_q;
    mcause_d  = mcause_q;
    if (we) begin
      case (waddr)
        CsrMstatus: mstatus_d = wdata;
        CsrMtvec:   mtvec_d   = wdata;
        CsrMepc:    mepc_d    = wdata;
        CsrMcause:  mcause_d  = wdata;
        default:    ;
      endcase
    end
    if (trap) begin
      mepc_d   = trap_pc;
      mcause_d = trap_cause;
    end
    // Derived from the old value, so any software write to mstatus is discarded.
    if (mret) begin
      mstatus_d = mret_mstatus(mstatus_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mstatus_q <= MSTATUS_RST;
      mtvec_q   <= MTVEC_RST;
      mepc_q    <= '0;
      mcause_q  <= '0;
    end else begin
      mstatus_q <= mstatus_d;
      mtvec_q   <= mtvec_d;
      mepc_q    <= mepc_d;
      mcause_q  <= mcause_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (raddr)
      CsrMstatus: rdata = mstatus_q;
      CsrMtvec:   rdata = mtvec_q;
      CsrMepc:    rdata = mepc_q;
      CsrMcause:  rdata = mcause_q;
      default:    rdata = '0;
    endcase
  end

  assign mtvec = mtvec_q;
  assign mepc  = mepc_q;

endmodule

// File: rtl/ysyx_25020037_wbu.sv
// Write-back / commit stage.
//   clk, rst            : clock, synchronous active-low reset
//   bus (slave)         : LSU retire handshake in, IFU next-PC handshake out
//   csr_raddr/csr_rdata : combinational CSR read for the EXU
//   gpr_we/waddr/wdata  : GPR write port, pulses for the single COMMIT cycle
// One instruction in flight: IDLE (accept) -> COMMIT (1 cycle) -> HANDOFF (until ifu_ready).
module ysyx_25020037_wbu
  import ysyx_25020037_wbu_pkg::*;
#(
  parameter int unsigned GPR_AW      = 4,
  parameter logic [31:0] MSTATUS_RST = 32'h0000_1800,
  parameter logic [31:0] MTVEC_RST   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  ysyx_25020037_wbu_if.slave    bus,
  input  logic [11:0]           csr_raddr,
  output logic [31:0]           csr_rdata,
  output logic                  gpr_we,
  output logic [GPR_AW-1:0]     gpr_waddr,
  output logic [31:0]           gpr_wdata
);

  wbu_state_e state_q, state_d;

  // Instruction captured on accept.
  logic [31:0]       pc_q, dnpc_q, wdata_q, csr_wdata_q;
  logic [GPR_AW-1:0] rd_q;
  logic [11:0]       csr_waddr_q;
  logic              gpr_we_q, is_read_q, is_write_q, fault_q, ecall_q, mret_q, csr_we_q;

  logic [31:0] npc_q, npc_d;
  logic        trap_q;

  logic        accept, commit, trap_c, mret_c;
  logic [31:0] trap_cause, mtvec, mepc;

  assign accept = bus.lsu_valid & (state_q == StIdle);
  assign commit = (state_q == StCommit);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (accept) state_d = StCommit;
      StCommit:  state_d = StHandoff;
      StHandoff: if (bus.ifu_ready) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // A fault outranks ecall, which outranks mret.
  always_comb begin
    trap_c     = fault_q | ecall_q;
    mret_c     = mret_q & ~trap_c;
    trap_cause = CauseEcallM;
    if (fault_q) begin
      trap_cause = (is_write_q & ~is_read_q) ? CauseStoreFault : CauseLoadFault;
    end
    if (trap_c) begin
      npc_d = mtvec;
    end else if (mret_c) begin
      npc_d = mepc;
    end else begin
      npc_d = dnpc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      pc_q        <= '0;
      dnpc_q      <= '0;
      rd_q        <= '0;
      gpr_we_q    <= 1'b0;
      wdata_q     <= '0;
      is_read_q   <= 1'b0;
      is_write_q  <= 1'b0;
      fault_q     <= 1'b0;
      ecall_q     <= 1'b0;
      mret_q      <= 1'b0;
      csr_we_q    <= 1'b0;
      csr_waddr_q <= '0;
      csr_wdata_q <= '0;
      npc_q       <= '0;
      trap_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        pc_q        <= bus.lu_pc;
        dnpc_q      <= bus.lu_dnpc;
        rd_q        <= bus.lu_rd;
        gpr_we_q    <= bus.lu_gpr_we;
        wdata_q     <= bus.lu_wdata;
        is_read_q   <= bus.lu_is_read;
        is_write_q  <= bus.lu_is_write;
        fault_q     <= bus.lu_access_fault;
        ecall_q     <= bus.lu_ecall;
        mret_q      <= bus.lu_mret;
        csr_we_q    <= bus.lu_csr_we;
        csr_waddr_q <= bus.lu_csr_waddr;
        csr_wdata_q <= bus.lu_csr_wdata;
      end
      // npc/trap stay frozen through HANDOFF until the next commit.
      if (commit) begin
        npc_q  <= npc_d;
        trap_q <= trap_c;
      end
    end
  end

  ysyx_25020037_csr_file #(
    .MSTATUS_RST (MSTATUS_RST),
    .MTVEC_RST   (MTVEC_RST)
  ) u_csr_file (
    .clk        (clk),
    .rst        (rst),
    .raddr      (csr_raddr),
    .rdata      (csr_rdata),
    .we         (commit & csr_we_q & ~trap_c),
    .waddr      (csr_waddr_q),
    .wdata      (csr_wdata_q),
    .trap       (commit & trap_c),
    .trap_pc    (pc_q),
    .trap_cause (trap_cause),
    .mret       (commit & mret_c),
    .mtvec      (mtvec),
    .mepc       (mepc)
  );

  // Gated by rst so an instruction caught by reset in COMMIT leaves no GPR trace.
  assign gpr_we    = commit & gpr_we_q & ~trap_c & (rd_q != '0) & rst;
  assign gpr_waddr = rd_q;
  assign gpr_wdata = wdata_q;

  assign bus.wbu_ready = (state_q == StIdle);
  assign bus.wbu_valid = (state_q == StHandoff);
  assign bus.wbu_npc   = npc_q;
  assign bus.wbu_trap  = trap_q;

endmodule
